// File: rtl/rv_pc_pkg.sv
// Shared types and immediate decoders for the fetch-PC generator.
// Immediates come back sign-extended to 64 bits; callers truncate to XLEN.
package rv_pc_pkg;

    typedef enum logic [1:0] {
        OP_JAL    = 2'd0,
        OP_JALR   = 2'd1,
        OP_BRANCH = 2'd2
    } pc_op_e;

    // Wide enough for FLUSH_STAGES up to 7.
    localparam int FLUSH_CNT_W = 3;

    function automatic logic [63:0] imm_j(input logic [31:0] instr);
        return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic logic [63:0] imm_i(input logic [31:0] instr);
        return {{52{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [63:0] imm_b(input logic [31:0] instr);
        return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/rv_pc_target.sv
// Combinational redirect-target calculation and misalignment detection.
module rv_pc_target
    import rv_pc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  pc_op_e            i_op,
    input  logic [XLEN-1:0]   i_execute_pc,
    input  logic [31:0]       i_instr,
    input  logic [XLEN-1:0]   i_rs1,
    output logic [XLEN-1:0]   o_target,
    output logic              o_misalign
);

    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_jalr_sum;

    assign w_imm_j    = XLEN'(imm_j(i_instr));
    assign w_imm_i    = XLEN'(imm_i(i_instr));
    assign w_imm_b    = XLEN'(imm_b(i_instr));
    assign w_jalr_sum = i_rs1 + w_imm_i;

    always_comb begin
        o_target = i_execute_pc + w_imm_b;
        case (i_op)
            OP_JAL:    o_target = i_execute_pc + w_imm_j;
            OP_JALR:   o_target = w_jalr_sum & ~XLEN'(1);
            OP_BRANCH: o_target = i_execute_pc + w_imm_b;
            default:   o_target = i_execute_pc + w_imm_b;
        endcase
    end

    // With compressed instructions any even address is legal.
    generate
        if (C_EXT) begin : g_cext
            assign o_misalign = 1'b0;
        end else begin : g_no_cext
            assign o_misalign = o_target[1];
        end
    endgenerate

endmodule

// File: rtl/rv_pc_gen.sv
// Fetch-PC generator: sequential PC, held redirects, trap vectoring,
// multi-cycle flush and misaligned-target reporting.
module rv_pc_gen
    import rv_pc_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] TRAP_VECTOR  = 64'h100,
    parameter int          FLUSH_STAGES = 2,
    parameter bit          C_EXT        = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fetch_ready,
    input  logic              stall,
    input  logic              redirect_valid,
    input  pc_op_e            redirect_op,
    input  logic [XLEN-1:0]   execute_pc,
    input  logic [31:0]       instr,
    input  logic [XLEN-1:0]   rs1,
    input  logic              trap_valid,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic              flush,
    output logic              halt,
    output logic              misalign_trap,
    output logic [XLEN-1:0]   misalign_addr
);

    localparam logic [XLEN-1:0]        RST_PC    = XLEN'(RESET_VECTOR);
    localparam logic [XLEN-1:0]        TRAP_PC   = XLEN'(TRAP_VECTOR);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LD  = FLUSH_CNT_W'(FLUSH_STAGES);

    logic [XLEN-1:0]        r_pc;
    logic [XLEN-1:0]        r_pend_pc;
    logic                   r_pending;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic                   r_halt;
    logic                   r_misalign_trap;
    logic [XLEN-1:0]        r_misalign_addr;

    logic [XLEN-1:0] w_target;
    logic            w_misalign;
    logic            w_advance;
    logic            w_accept;
    logic            w_load;
    logic            w_mis_fire;
    logic [XLEN-1:0] w_new_target;
    logic [XLEN-1:0] w_pc_plus4;

    rv_pc_target #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_target (
        .i_op         (redirect_op),
        .i_execute_pc (execute_pc),
        .i_instr      (instr),
        .i_rs1        (rs1),
        .o_target     (w_target),
        .o_misalign   (w_misalign)
    );

    assign w_advance    = enable & fetch_ready & ~stall;
    // While a redirect is pending, younger redirects are wrong-path and dropped.
    assign w_accept     = redirect_valid & ~r_pending;
    assign w_load       = trap_valid | w_accept;
    assign w_mis_fire   = w_accept & ~trap_valid & w_misalign;
    assign w_new_target = (trap_valid | w_mis_fire) ? TRAP_PC : w_target;
    assign w_pc_plus4   = r_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RST_PC;
            r_pend_pc       <= RST_PC;
            r_pending       <= 1'b0;
            r_flush_cnt     <= '0;
            r_halt          <= 1'b0;
            r_misalign_trap <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            if (w_advance) begin
                if (w_load) begin
                    r_pc <= w_new_target;
                end else if (r_pending) begin
                    r_pc <= r_pend_pc;
                end else begin
                    r_pc <= w_pc_plus4;
                end
                r_pending <= 1'b0;
            end else if (w_load) begin
                r_pending <= 1'b1;
                r_pend_pc <= w_new_target;
            end

            if (w_load) begin
                r_flush_cnt <= FLUSH_LD;
            end else if (r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end

            r_halt          <= ~enable;
            r_misalign_trap <= w_mis_fire;
            if (w_mis_fire) begin
                r_misalign_addr <= w_target;
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign flush         = (r_flush_cnt != '0);
    assign halt          = r_halt;
    assign misalign_trap = r_misalign_trap;
    assign misalign_addr = r_misalign_addr;

endmodule
